// File: rtl/dyna_packet_tx.sv
// Dynamixel 1.0 instruction packet transmitter over a half-duplex UART 8N1 line.
// Optional bus turnaround hold is compiled in with macro DYNA_TX_TURNAROUND_EN.
module dyna_packet_tx #(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned BAUD        = 1000000,
   parameter int unsigned MAX_PARAMS  = 8,
   parameter int unsigned TURN_CYCLES = 100,
   localparam int unsigned NpW        = $clog2(MAX_PARAMS + 1)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [7:0]              id,
   input  logic [7:0]              instr,
   input  logic [NpW-1:0]          nparams,
   input  logic [8*MAX_PARAMS-1:0] params,
   output logic                    tx,
   output logic                    tx_en,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int unsigned Div      = CLK_HZ / BAUD;
   localparam int unsigned MaxCnt   = (Div > TURN_CYCLES) ? Div : TURN_CYCLES;
   localparam int unsigned CntW     = $clog2(MaxCnt + 1);
   localparam int unsigned ByteW    = $clog2(MAX_PARAMS + 7);
   localparam int unsigned PiW      = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
   localparam int unsigned TurnLast = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StTurn} state_e;

   state_e                         state_q, state_d;
   logic [CntW-1:0]                cnt_q, cnt_d;
   logic [2:0]                     bit_q, bit_d;
   logic [ByteW-1:0]               byte_q, byte_d;
   logic [7:0]                     id_q, id_d;
   logic [7:0]                     instr_q, instr_d;
   logic [NpW-1:0]                 np_q, np_d;
   logic [MAX_PARAMS-1:0][7:0]     params_q, params_d;
   logic [7:0]                     chk_q, chk_d;
   logic                           done_q, done_d;
   logic                           err_q, err_d;

   logic [7:0]                     sum_in;
   logic [7:0]                     cur_byte;
   logic [ByteW-1:0]               last_byte;
   logic [PiW-1:0]                 pidx;
   logic                           cnt_last;

   // Checksum over the request as presented, so it is ready before the first byte goes out.
   always_comb begin
      sum_in = id + 8'(nparams) + 8'd2 + instr;
      for (int i = 0; i < MAX_PARAMS; i++) begin
         if (i < int'(nparams)) sum_in = sum_in + params[8*i +: 8];
      end
   end

   assign last_byte = ByteW'(np_q) + ByteW'(5);

   always_comb begin
      cur_byte = 8'hFF;
      pidx     = PiW'(byte_q - ByteW'(5));
      if (byte_q == ByteW'(2)) begin
         cur_byte = id_q;
      end else if (byte_q == ByteW'(3)) begin
         cur_byte = 8'(np_q) + 8'd2;
      end else if (byte_q == ByteW'(4)) begin
         cur_byte = instr_q;
      end else if (byte_q == last_byte) begin
         cur_byte = chk_q;
      end else if (byte_q > ByteW'(4)) begin
         cur_byte = params_q[pidx];
      end
   end

   assign cnt_last = (cnt_q == CntW'(Div - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      id_d     = id_q;
      instr_d  = instr_q;
      np_d     = np_q;
      params_d = params_q;
      chk_d    = chk_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (nparams > NpW'(MAX_PARAMS)) begin
                  err_d = 1'b1;
               end else begin
                  id_d     = id;
                  instr_d  = instr;
                  np_d     = nparams;
                  params_d = params;
                  chk_d    = ~sum_in;
                  cnt_d    = '0;
                  byte_d   = '0;
                  state_d  = StStart;
               end
            end
         end
         StStart: begin
            if (cnt_last) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (bit_q == 3'd7) state_d = StStop;
               else               bit_d   = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (byte_q == last_byte) begin
`ifdef DYNA_TX_TURNAROUND_EN
                  state_d = StTurn;
`else
                  state_d = StIdle;
                  done_d  = 1'b1;
`endif
               end else begin
                  byte_d  = byte_q + 1'b1;
                  state_d = StStart;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StTurn: begin
            if (cnt_q == CntW'(TurnLast)) begin
               cnt_d   = '0;
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         id_q     <= '0;
         instr_q  <= '0;
         np_q     <= '0;
         params_q <= '0;
         chk_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         id_q     <= id_d;
         instr_q  <= instr_d;
         np_q     <= np_d;
         params_q <= params_d;
         chk_q    <= chk_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      tx = 1'b1;
      if (state_q == StStart)     tx = 1'b0;
      else if (state_q == StData) tx = cur_byte[bit_q];
   end

   assign busy  = (state_q != StIdle);
   assign tx_en = busy;
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_dyna_packet_tx.sv
// Randomized bench for dyna_packet_tx: decodes the UART line and compares against a
// byte-level packet model built from the Dynamixel 1.0 framing rules.
module tb_dyna_packet_tx;

   localparam int MaxP = 8;
   localparam int Div  = 50;
   localparam int NpW  = 4;
`ifdef DYNA_TX_TURNAROUND_EN
   localparam int TurnLen = 100;
`else
   localparam int TurnLen = 0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [7:0]        id;
   logic [7:0]        instr;
   logic [NpW-1:0]    nparams;
   logic [8*MaxP-1:0] params;
   logic              tx, tx_en, busy, done, err;

   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] exp_q[$];
   logic       rec[$];

   always #5 clk = ~clk;

   dyna_packet_tx #(
      .CLK_HZ     (50000000),
      .BAUD       (1000000),
      .MAX_PARAMS (MaxP),
      .TURN_CYCLES(100)
   ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .id     (id),
      .instr  (instr),
      .nparams(nparams),
      .params (params),
      .tx     (tx),
      .tx_en  (tx_en),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected byte stream: FF FF id LEN instr P0..Pn-1 CHK.
   task automatic model_packet(input logic [7:0] pid, input logic [7:0] pins, input int n,
                               input logic [8*MaxP-1:0] pp);
      int sum;
      exp_q.delete();
      sum = int'(pid) + n + 2 + int'(pins);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(pid);
      exp_q.push_back(8'(n + 2));
      exp_q.push_back(pins);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pp[8*i +: 8]);
         sum += int'(pp[8*i +: 8]);
      end
      exp_q.push_back(~8'(sum % 256));
   endtask

   // Called and returns at a falling edge; returns on the done cycle.
   task automatic send_packet(input logic [7:0] pid, input logic [7:0] pins, input int n,
                              input logic [8*MaxP-1:0] pp, input int poke);
      int busy_cnt, en_bad, done_bad, exp_len, limit, turn_bad;
      logic [7:0] b;
      model_packet(pid, pins, n, pp);
      exp_len = exp_q.size() * 10 * Div + TurnLen;
      limit   = exp_len + 200;
      id = pid; instr = pins; nparams = NpW'(n); params = pp; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_eq("first_busy", busy, 1);
      check_eq("first_tx_en", tx_en, 1);
      check_eq("first_tx", tx, 0);
      id = 8'($urandom); instr = 8'($urandom); nparams = NpW'($urandom_range(0, 9));
      params = {$urandom, $urandom};
      rec.delete();
      rec.push_back(tx);
      busy_cnt = 1; en_bad = 0; done_bad = 0;
      while (1) begin
         @(negedge clk);
         if (busy !== 1'b1 || busy_cnt > limit) break;
         busy_cnt++;
         rec.push_back(tx);
         if (tx_en !== 1'b1) en_bad++;
         if (done !== 1'b0) done_bad++;
         start = (poke > 0 && busy_cnt >= poke && busy_cnt < poke + 4);
      end
      start = 1'b0;
      check_eq("busy_len", busy_cnt, exp_len);
      check_eq("done_at_end", done, 1);
      check_eq("tx_en_low_at_end", tx_en, 0);
      check_eq("done_during_busy", done_bad, 0);
      check_eq("tx_en_during_busy", en_bad, 0);
      if (rec.size() < exp_q.size() * 10 * Div) begin
         check_eq("frame_len", rec.size(), exp_q.size() * 10 * Div);
      end else begin
         foreach (exp_q[k]) begin
            int base;
            base = k * 10 * Div + Div / 2;
            check_eq($sformatf("start_bit%0d", k), rec[base], 0);
            for (int j = 0; j < 8; j++) b[j] = rec[base + (j + 1) * Div];
            check_eq($sformatf("byte%0d", k), b, exp_q[k]);
            check_eq($sformatf("stop_bit%0d", k), rec[base + 9 * Div], 1);
         end
         turn_bad = 0;
         for (int i = exp_q.size() * 10 * Div; i < rec.size(); i++) if (rec[i] !== 1'b1) turn_bad++;
         check_eq("turn_tx_high", turn_bad, 0);
      end
   endtask

   initial begin
      int n;
      int hits;
      reset_n = 1'b0; start = 1'b0; id = '0; instr = '0; nparams = '0; params = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx", tx, 1);
      check_eq("rst_tx_en", tx_en, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      reset_n = 1'b1;
      @(negedge clk);

      send_packet(8'h01, 8'h03, 2, 64'h1901, 0);
      @(negedge clk);
      check_eq("done_one_cycle", done, 0);
      check_eq("idle_tx", tx, 1);

      send_packet(8'h01, 8'h01, 0, 64'h0, 0);
      @(negedge clk);
      send_packet(8'hFE, 8'h03, 2, 64'hFFFF, 0);
      @(negedge clk);

      // Oversized request is rejected without touching the line.
      nparams = NpW'(9); id = 8'h05; instr = 8'h03; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_eq("err_pulse", err, 1);
      check_eq("err_busy", busy, 0);
      check_eq("err_tx", tx, 1);
      check_eq("err_tx_en", tx_en, 0);
      @(negedge clk);
      check_eq("err_one_cycle", err, 0);
      check_eq("err_busy_after", busy, 0);

      send_packet(8'($urandom), 8'($urandom), 3, {$urandom, $urandom}, 700);
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(0, MaxP);
         send_packet(8'($urandom), 8'($urandom), n, {$urandom, $urandom}, 0);
      end
      @(negedge clk);

      // Reset in the middle of a data bit of byte 3 aborts the packet.
      id = 8'h01; instr = 8'h03; nparams = NpW'(2); params = 64'h1901; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3 * 10 * Div + 3 * Div + 10) @(negedge clk);
      check_eq("pre_rst_busy", busy, 1);
      reset_n = 1'b0; start = 1'b1;
      @(negedge clk);
      check_eq("abort_tx", tx, 1);
      check_eq("abort_tx_en", tx_en, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      reset_n = 1'b1; start = 1'b0;
      hits = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) hits++;
      end
      check_eq("abort_quiet", hits, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dyna_packet_tx.md
DYNA_PACKET_TX -- requirements
Module: dyna_packet_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 1000000, serial bit rate; DIV = CLK_HZ/BAUD (integer, >=4).
REQ-003 SHALL have parameter MAX_PARAMS, default 8, maximum instruction parameter bytes per packet.
REQ-004 SHALL have parameter TURN_CYCLES, default 100, bus turnaround hold in clock cycles.
REQ-005 SHALL have port clk  input  1  system clock, single clock domain.
REQ-006 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port start  input  1  request to send one packet.
REQ-008 SHALL have port id  input  8  servo ID (0xFE = broadcast).
REQ-009 SHALL have port instr  input  8  Dynamixel 1.0 instruction code.
REQ-010 SHALL have port nparams  input  $clog2(MAX_PARAMS+1)  parameter byte count.
REQ-011 SHALL have port params  input  8*MAX_PARAMS  parameter bytes, P0 in bits [7:0], Pk in [8k+7:8k].
REQ-012 SHALL have port tx  output  1  UART 8N1 line, LSB first, idle high.
REQ-013 SHALL have port tx_en  output  1  half-duplex driver enable, high = drive bus.
REQ-014 SHALL have port busy  output  1  packet in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse, packet complete.
REQ-016 SHALL have port err  output  1  one-cycle pulse, request rejected.

Function
REQ-017 SHALL accept start only when busy=0; start while busy=1 ignored, no queuing.
REQ-018 SHALL latch id, instr, nparams, params on the accept cycle; later input changes have no effect on the packet in progress.
REQ-019 SHALL reject a request with nparams>MAX_PARAMS: err pulses the following cycle, busy stays 0, tx/tx_en unchanged.
REQ-020 SHALL transmit bytes FF, FF, id, LEN, instr, P0..P(n-1), CHK with LEN = nparams+2.
REQ-021 SHALL compute CHK = bitwise NOT of low 8 bits of (id+LEN+instr+sum of params), sum wrapping modulo 256.
REQ-022 SHALL frame each byte as start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly DIV cycles, no gap between bytes.
REQ-023 SHALL assert busy and tx_en and drive tx=0 (first start bit) on the cycle after acceptance.
REQ-024 SHALL use states IDLE -> START -> DATA -> STOP -> (START if bytes remain, else TURN or IDLE).
REQ-025 SHALL pulse done and deassert busy in the same cycle, immediately after the final phase (TURN if compiled in, else final stop bit) completes.
REQ-026 SHALL accept a new start in the cycle busy is low after done, giving back-to-back packets.
REQ-027 SHALL hold tx=1 whenever not in START or DATA.

Reset
REQ-028 SHALL, on a clk edge with reset_n=0, set tx=1, tx_en=0, busy=0, done=0, err=0, state IDLE, counters zero.
REQ-029 SHALL abort any packet in progress on reset; no done pulse for the aborted packet.
REQ-030 SHALL ignore start while reset_n=0.

Configuration
REQ-031 SHALL recognise macro DYNA_TX_TURNAROUND_EN.
REQ-032 SHALL, when DYNA_TX_TURNAROUND_EN is defined, enter TURN after the last stop bit, holding tx_en=1, tx=1, busy=1 for TURN_CYCLES cycles before done.
REQ-033 SHALL, when DYNA_TX_TURNAROUND_EN is undefined, omit TURN; tx_en and busy fall and done pulses the cycle after the last stop bit ends.

Verification (CLK_HZ=50000000, BAUD=1000000, DIV=50, turnaround undefined unless stated)
REQ-034 SHALL cover: id=01, instr=03, nparams=2, params={01,19} -> bytes FF FF 01 04 03 19 01 DD, busy high 4000 cycles, one done pulse.
REQ-035 SHALL cover: ping id=01, instr=01, nparams=0 -> FF FF 01 02 01 FB, 3000 cycles.
REQ-036 SHALL cover checksum wrap: id=FE, instr=03, params={FF,FF} -> CHK=FC.
REQ-037 SHALL cover: nparams=9 with MAX_PARAMS=8 -> err pulse, tx stays 1, busy stays 0; start during busy -> ignored, packet unchanged.
REQ-038 SHALL cover: reset_n low for one cycle mid-DATA of byte 3 -> next cycle tx=1, tx_en=0, busy=0, no done.
REQ-039 SHALL cover: DYNA_TX_TURNAROUND_EN defined, TURN_CYCLES=100, ping packet -> tx_en high 3100 cycles, done at end of TURN.
